// File: rtl/riscv_pkg.sv
// riscv_pkg: shared core types, fetch FSM encoding, NOP word and opcode constants.
package riscv_pkg;
    localparam int XLEN = 32;
    typedef logic [XLEN-1:0] word_t;
    localparam word_t NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    function automatic logic is_aligned(input word_t a);
        return a[1:0] == 2'b00;
    endfunction
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: fetch-stage bus; perf counters appear only with FETCH_PERF_EN.
interface instruction_fetch_unit_if;
    import riscv_pkg::*;
    logic  stall_i;
    logic  flush_i;
    logic  redirect_valid_i;
    word_t redirect_pc_i;
    word_t imem_addr_o;
    word_t imem_instr_i;
    logic  ifid_valid_o;
    word_t ifid_pc_o;
    word_t ifid_pc_plus4_o;
    word_t ifid_instr_o;
    logic  misalign_o;
`ifdef FETCH_PERF_EN
    word_t perf_fetched_o;
    word_t perf_stall_o;
    modport master(input stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
                   output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
                   misalign_o, perf_fetched_o, perf_stall_o);
    modport slave(output stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
                  input imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
                  misalign_o, perf_fetched_o, perf_stall_o);
`else
    modport master(input stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
                   output imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
                   misalign_o);
    modport slave(output stall_i, flush_i, redirect_valid_i, redirect_pc_i, imem_instr_i,
                  input imem_addr_o, ifid_valid_o, ifid_pc_o, ifid_pc_plus4_o, ifid_instr_o,
                  misalign_o);
`endif
endinterface

// File: rtl/instruction_fetch_unit_ifid_reg.sv
// ifid_reg: IF/ID pipeline register; bubble beats load, otherwise holds.
module ifid_reg
    import riscv_pkg::*;
#(
    parameter word_t BUBBLE_INSTR = 32'h0000_0013
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_load,
    input  logic  i_bubble,
    input  word_t i_pc,
    input  word_t i_instr,
    output logic  o_valid,
    output word_t o_pc,
    output word_t o_pc_plus4,
    output word_t o_instr
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            o_valid    <= 1'b0;
            o_pc       <= '0;
            o_pc_plus4 <= 32'd4;
            o_instr    <= BUBBLE_INSTR;
        end else if (i_bubble) begin
            o_valid <= 1'b0;
            o_instr <= BUBBLE_INSTR;
        end else if (i_load) begin
            o_valid    <= 1'b1;
            o_pc       <= i_pc;
            o_pc_plus4 <= i_pc + 32'd4;
            o_instr    <= i_instr;
        end
endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC, BOOT/RUN/TRAP FSM and redirect/flush/stall priority.
// Defining FETCH_PERF_EN adds fetched/stall event counters.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_fetch_unit_if.master bus
);
    import riscv_pkg::*;
    word_t      r_pc;
    logic [1:0] r_state;
    logic       r_misalign;
    logic       w_run, w_redir_ok, w_redir_bad, w_bubble, w_load, w_pc_inc;
    word_t      w_pc_next;
    logic [1:0] w_state_next;
    assign w_run       = r_state == ST_RUN;
    assign w_redir_ok  = bus.redirect_valid_i && is_aligned(bus.redirect_pc_i);
    assign w_redir_bad = bus.redirect_valid_i && !is_aligned(bus.redirect_pc_i);
    assign w_bubble    = w_run && (bus.redirect_valid_i || bus.flush_i);
    assign w_load      = w_run && !bus.redirect_valid_i && !bus.flush_i && !bus.stall_i;
    assign w_pc_inc    = w_run && !bus.redirect_valid_i && !bus.stall_i;
    // An aligned redirect is honoured in every state, including BOOT and TRAP.
    assign w_pc_next    = w_redir_ok ? bus.redirect_pc_i : w_pc_inc ? r_pc + 32'd4 : r_pc;
    assign w_state_next = (r_state == ST_BOOT) ? ST_RUN :
                          (w_run && w_redir_bad) ? ST_TRAP :
                          (r_state == ST_TRAP && w_redir_ok) ? ST_RUN : r_state;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_pc       <= RESET_VECTOR;
            r_state    <= ST_BOOT;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_state    <= w_state_next;
            r_misalign <= (w_run && w_redir_bad) ? 1'b1 :
                          (r_state == ST_TRAP && w_redir_ok) ? 1'b0 : r_misalign;
        end
    assign bus.imem_addr_o = r_pc;
    assign bus.misalign_o  = r_misalign;
    ifid_reg #(.BUBBLE_INSTR(NOP_INSTR)) u_ifid (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_load    (w_load),
        .i_bubble  (w_bubble),
        .i_pc      (r_pc),
        .i_instr   (bus.imem_instr_i),
        .o_valid   (bus.ifid_valid_o),
        .o_pc      (bus.ifid_pc_o),
        .o_pc_plus4(bus.ifid_pc_plus4_o),
        .o_instr   (bus.ifid_instr_o)
    );
`ifdef FETCH_PERF_EN
    word_t r_fetched, r_stalled;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_fetched <= '0;
            r_stalled <= '0;
        end else begin
            r_fetched <= r_fetched + {31'd0, w_load};
            r_stalled <= r_stalled + {31'd0, w_run && !bus.redirect_valid_i && !bus.flush_i && bus.stall_i};
        end
    assign bus.perf_fetched_o = r_fetched;
    assign bus.perf_stall_o   = r_stalled;
`endif
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed plan steps plus random traffic against a rule-level model.
module tb_instruction_fetch_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    logic [31:0] m_pc, m_ipc, m_instr, m_pf, m_ps;
    logic m_v, m_mis;
    int m_mode;
    instruction_fetch_unit_if bus();
    instruction_fetch_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h10) return 32'h003100B3;
        if (a < 32'h10) return 32'h0;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction
    assign bus.imem_instr_i = mem(bus.imem_addr_o);
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic model_reset();
        m_pc = 32'h0; m_mode = 0; m_v = 1'b0; m_ipc = 32'h0; m_instr = 32'h13;
        m_mis = 1'b0; m_pf = 0; m_ps = 0;
    endtask
    // mode: 0 boot, 1 run, 2 trap
    task automatic model_step(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
        logic al;
        al = (rpc % 4) == 0;
        if (m_mode == 0) begin
            if (rv && al) m_pc = rpc;
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (rv && al) begin m_pc = rpc; m_mis = 1'b0; m_mode = 1; end
        end else if (rv) begin
            m_v = 1'b0; m_instr = 32'h13;
            if (al) m_pc = rpc;
            else begin m_mis = 1'b1; m_mode = 2; end
        end else if (f) begin
            m_v = 1'b0; m_instr = 32'h13;
            if (!s) m_pc = m_pc + 4;
        end else if (s) m_ps = m_ps + 1;
        else begin
            m_v = 1'b1; m_ipc = m_pc; m_instr = mem(m_pc); m_pc = m_pc + 4; m_pf = m_pf + 1;
        end
    endtask
    task automatic check_all(input string tag);
        chk({tag, ".addr"}, bus.imem_addr_o, m_pc);
        chk({tag, ".valid"}, {31'd0, bus.ifid_valid_o}, {31'd0, m_v});
        chk({tag, ".instr"}, bus.ifid_instr_o, m_instr);
        chk({tag, ".mis"}, {31'd0, bus.misalign_o}, {31'd0, m_mis});
        if (m_v) begin
            chk({tag, ".ipc"}, bus.ifid_pc_o, m_ipc);
            chk({tag, ".ipc4"}, bus.ifid_pc_plus4_o, m_ipc + 32'd4);
        end
`ifdef FETCH_PERF_EN
        chk({tag, ".pf"}, bus.perf_fetched_o, m_pf);
        chk({tag, ".ps"}, bus.perf_stall_o, m_ps);
`endif
    endtask
    task automatic cycle(input logic s, input logic f, input logic rv, input logic [31:0] rpc);
        bus.stall_i = s; bus.flush_i = f; bus.redirect_valid_i = rv; bus.redirect_pc_i = rpc;
        @(posedge clk);
        model_step(s, f, rv, rpc);
        #1 check_all("cyc");
    endtask
    initial begin
        bus.stall_i = 0; bus.flush_i = 0; bus.redirect_valid_i = 0; bus.redirect_pc_i = 0;
        model_reset();
        #12;
        chk("rst_addr", bus.imem_addr_o, 32'h0);
        chk("rst_valid", {31'd0, bus.ifid_valid_o}, 32'd0);
        chk("rst_ipc", bus.ifid_pc_o, 32'h0);
        chk("rst_ipc4", bus.ifid_pc_plus4_o, 32'h4);
        chk("rst_instr", bus.ifid_instr_o, 32'h13);
        chk("rst_mis", {31'd0, bus.misalign_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("boot_addr", bus.imem_addr_o, 32'h0);
        cycle(0, 0, 0, 0);
        chk("boot_novalid", {31'd0, bus.ifid_valid_o}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("first_valid", {31'd0, bus.ifid_valid_o}, 32'd1);
        chk("first_pc", bus.ifid_pc_o, 32'h0);
        repeat (4) cycle(0, 0, 0, 0);
        chk("pc10", bus.ifid_pc_o, 32'h10);
        chk("instr10", bus.ifid_instr_o, 32'h003100B3);
        repeat (3) cycle(1, 0, 0, 0);
        chk("stall_addr", bus.imem_addr_o, 32'h14);
        chk("stall_ipc", bus.ifid_pc_o, 32'h10);
        cycle(0, 0, 0, 0);
        chk("after_stall", bus.ifid_pc_o, 32'h14);
        cycle(1, 1, 1, 32'h40);
        chk("redir_addr", bus.imem_addr_o, 32'h40);
        chk("redir_bubble", bus.ifid_instr_o, 32'h13);
        cycle(0, 0, 0, 0);
        chk("redir_cap", bus.ifid_pc_o, 32'h40);
        cycle(0, 0, 1, 32'h42);
        chk("mis_set", {31'd0, bus.misalign_o}, 32'd1);
        chk("mis_pc", bus.imem_addr_o, 32'h44);
        cycle(0, 1, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        chk("trap_hold", bus.imem_addr_o, 32'h44);
        chk("trap_valid", {31'd0, bus.ifid_valid_o}, 32'd0);
        cycle(0, 0, 1, 32'h80);
        chk("mis_clr", {31'd0, bus.misalign_o}, 32'd0);
        cycle(0, 0, 0, 0);
        chk("resume", bus.ifid_pc_o, 32'h80);
        cycle(0, 0, 1, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        chk("wrap_a", bus.ifid_pc_o, 32'hFFFF_FFFC);
        cycle(0, 0, 0, 0);
        chk("wrap_b", bus.ifid_pc_o, 32'h0);
        for (int i = 0; i < 400; i++) begin
            logic rv;
            logic [31:0] t;
            rv = $urandom_range(0, 99) < 8;
            t = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
            cycle($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, rv, t);
        end
        cycle(0, 0, 1, 32'h10);
        repeat (3) cycle(0, 0, 0, 0);
        chk("pre_rst_pc", bus.imem_addr_o, 32'h1C);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_addr", bus.imem_addr_o, 32'h0);
        chk("arst_valid", {31'd0, bus.ifid_valid_o}, 32'd0);
        chk("arst_mis", {31'd0, bus.misalign_o}, 32'd0);
`ifdef FETCH_PERF_EN
        chk("arst_pf", bus.perf_fetched_o, 32'd0);
        chk("arst_ps", bus.perf_stall_o, 32'd0);
`endif
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        repeat (4) cycle(0, 0, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
